// File: rtl/counter_load_sequencer.sv
// Queues counter presets and drives load/data_in/rst of a loadable counter, chaining segments at TERM.
// Latency: a preset pushed into an empty FIFO in IDLE loads the next cycle; seq_done follows exit by one cycle.
// Backpressure: in_ready is low whenever the FIFO holds DEPTH entries, even if a pop happens that cycle.
module counter_load_sequencer #(
    parameter int              WIDTH = 4,
    parameter int              DEPTH = 4,
    parameter logic [WIDTH-1:0] TERM = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           count,
    output logic                       load,
    output logic [WIDTH-1:0]           data_out,
    output logic                       ctr_rst,
    output logic                       busy,
    output logic                       seq_done,
    output logic [$clog2(DEPTH+1)-1:0] fill
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             seq_done_q, seq_done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             at_term;
    logic             push;
    logic             pop;

    assign empty    = (fill_q == '0);
    assign at_term  = (count == TERM);
    assign in_ready = (fill_q != FW'(DEPTH));
    // Only two states exist, so "not IDLE" already means RUN here.
    assign load     = !empty && !abort && ((state_q == IDLE) || at_term);
    assign push     = in_valid && in_ready && !abort;
    assign pop      = load;

    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    assign ctr_rst  = (state_q == IDLE);
    assign busy     = (state_q == RUN);
    assign seq_done = seq_done_q;
    assign fill     = fill_q;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        seq_done_d = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      fill_d = fill_q + FW'(1);
            else if (!push && pop) fill_d = fill_q - FW'(1);
            if (load) begin
                state_d = RUN;
            end else if ((state_q == RUN) && at_term && empty) begin
                state_d    = IDLE;
                seq_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            seq_done_q <= seq_done_d;
        end
    end

    // Storage needs no reset: data_out is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end
endmodule

// File: tb/tb_counter_load_sequencer.sv
// Bench for counter_load_sequencer with a behavioural model of the 4-bit loadable counter attached.
module tb_counter_load_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       abort;
    logic       in_ready;
    logic       load;
    logic [3:0] data_out;
    logic       ctr_rst;
    logic       busy;
    logic       seq_done;
    logic [2:0] fill;
    logic [3:0] count = 4'h0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [3:0] sb_q[$];
    logic [3:0] obs_q[$];

    typedef struct {
        logic       vld;
        logic [3:0] din;
        logic       ld;
        logic [3:0] dout;
        logic       bsy;
        logic       dn;
        logic       crst;
        logic [2:0] fl;
        logic [3:0] cnt;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    counter_load_sequencer #(.WIDTH(4), .DEPTH(4), .TERM(4'hF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .count(count), .load(load), .data_out(data_out), .ctr_rst(ctr_rst),
        .busy(busy), .seq_done(seq_done), .fill(fill)
    );

    // Downstream counter: load beats its synchronous rst, otherwise it counts up.
    always @(posedge clk) begin
        if (load)         count <= data_out;
        else if (ctr_rst) count <= 4'h0;
        else              count <= count + 4'd1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard: accepted presets must come back out on load in order; flushes empty it.
    always @(negedge clk) begin
        if (!rst || abort) begin
            sb_q.delete();
        end else begin
            if (load) begin
                chk("sb_load_pending", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) chk("sb_load_data", data_out, sb_q.pop_front());
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
        end
        if (rst && seq_done) done_cnt++;
        if (rst && busy) obs_q.push_back(count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (seq_done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_seq_done", seq_done, 1);
        @(negedge clk);
        chk("seq_done_width", seq_done, 0);
        chk("exit_ctr_rst", ctr_rst, 1);
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_fill"}, fill, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ctr_rst"}, ctr_rst, 1);
        chk({tag, "_seq_done"}, seq_done, 0);
    endtask

    initial begin
        int waited;
        int accepted;
        logic [3:0] exp_cnt[$];

        // Reset held with pushes offered
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h5; abort = 1'b0;
        #1 rst = 1'b0; in_valid = 1'b1;
        #1 chk_reset_outs("rst");
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("rst_pending_fill", fill, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_load", i), load, 0);
            chk($sformatf("post_rst%0d_fill", i), fill, 0);
        end
        tick();

        // Single preset 4'hC, cycle by cycle
        tbl[0] = '{1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0};
        tbl[1] = '{1'b0, 4'h0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 3'd1, 4'h0};
        tbl[2] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hC};
        tbl[3] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hD};
        tbl[4] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hE};
        tbl[5] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hF};
        tbl[6] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd0, 4'h0};
        tbl[7] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].vld;
            in_data  = tbl[i].din;
            @(negedge clk);
            chk($sformatf("tbl%0d_load", i), load, tbl[i].ld);
            chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), seq_done, tbl[i].dn);
            chk($sformatf("tbl%0d_ctr_rst", i), ctr_rst, tbl[i].crst);
            chk($sformatf("tbl%0d_fill", i), fill, tbl[i].fl);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            tick();
        end
        in_valid = 1'b0;

        // Chained E, 3, F: no gap between segments, F is a one-cycle segment
        obs_q.delete();
        done_cnt = 0;
        push1(4'hE); push1(4'h3); push1(4'hF);
        wait_done(60);
        exp_cnt = '{4'hE, 4'hF};
        for (int v = 3; v <= 15; v++) exp_cnt.push_back(4'(v));
        exp_cnt.push_back(4'hF);
        chk("chain_len", obs_q.size(), exp_cnt.size());
        for (int i = 0; i < exp_cnt.size() && i < obs_q.size(); i++)
            chk($sformatf("chain_count%0d", i), obs_q[i], exp_cnt[i]);
        chk("chain_done_pulses", done_cnt, 1);
        chk("chain_sb_empty", sb_q.size(), 0);

        // Five presets with DEPTH 4: fifth held off until the first pop
        push1(4'h0);
        tick();
        push1(4'h8); push1(4'h9); push1(4'hA); push1(4'hB);
        @(negedge clk);
        chk("full_fill", fill, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 4'hC;
        waited = 0;
        accepted = 0;
        for (int n = 0; n < 40 && accepted == 0; n++) begin
            if (n != 0) @(negedge clk);
            if (load) chk("full_pop_in_ready", in_ready, 0);
            if (in_ready) accepted = 1; else waited++;
            tick();
        end
        in_valid = 1'b0;
        chk("full_accepted", accepted, 1);
        chk("full_wait_cycles", waited, 12);
        wait_done(120);
        chk("full_sb_empty", sb_q.size(), 0);

        // Back-to-back: push in the seq_done cycle loads on the next
        push1(4'hF);
        tick(); tick();
        in_valid = 1'b1; in_data = 4'hD;
        @(negedge clk);
        chk("b2b_done", seq_done, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_load", load, 1);
        chk("b2b_dout", data_out, 4'hD);
        wait_done(30);

        // Abort in RUN with two queued, with a same-cycle push
        done_cnt = 0;
        push1(4'h0); push1(4'h5); push1(4'h6);
        abort = 1'b1; in_valid = 1'b1; in_data = 4'h7;
        @(negedge clk);
        chk("abort_load", load, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_fill", fill, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ctr_rst", ctr_rst, 1);
        chk("abort_done", seq_done, 0);
        tick();
        @(negedge clk);
        chk("abort_count", count, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("abort_idle%0d_load", i), load, 0);
        end
        chk("abort_done_pulses", done_cnt, 0);
        tick();

        // Asynchronous reset mid-segment, away from the clock edge
        push1(4'h0); push1(4'h4); push1(4'h5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_reset_outs("arst");
        @(posedge clk);
        #1 chk("arst_count", count, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("arst_post%0d_load", i), load, 0);
            chk($sformatf("arst_post%0d_fill", i), fill, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
